// File: rtl/accu_result_fifo.sv
// accu_result_fifo: result buffer behind the 4-sample accumulator.
// Captures single-cycle result strobes into a small first-word-fall-through
// FIFO. Results leave through a valid/ready handshake. A strobe that arrives
// while the FIFO is full, with no pop in the same cycle, is dropped and
// flagged in the sticky ovf bit.
// Optional feature: define ACCU_FIFO_DROP_CNT_EN to add the saturating 8-bit
// drop_cnt output port.
module accu_result_fifo #(
  parameter int unsigned DW    = 10,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty,
  output logic          ovf,
  input  logic          ovf_clr
`ifdef ACCU_FIFO_DROP_CNT_EN
  ,
  output logic [7:0]    drop_cnt
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Storage array; contents are deliberately not reset
  logic [DW-1:0] mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr_nxt;
  logic [PW-1:0] wr_ptr_nxt;
  logic [LW-1:0] level_nxt;
  logic [DW-1:0] head_nxt;
  logic          push_c;
  logic          pop_c;
  logic          drop_c;

  // Handshake decode, pointer/level update and next head value
  always_comb begin
    pop_c      = out_valid & out_ready;
    push_c     = in_valid & (~full | pop_c);
    drop_c     = in_valid & full & ~pop_c;
    rd_ptr_nxt = rd_ptr;
    wr_ptr_nxt = wr_ptr;
    level_nxt  = level;
    if (pop_c) begin
      rd_ptr_nxt = rd_ptr + PW'(1);
    end
    if (push_c) begin
      wr_ptr_nxt = wr_ptr + PW'(1);
    end
    case ({push_c, pop_c})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
    // The incoming word becomes the head when it lands where the read
    // pointer will sit next (FIFO empty, or draining its last entry).
    if (push_c && (wr_ptr == rd_ptr_nxt)) begin
      head_nxt = in_data;
    end else begin
      head_nxt = mem[rd_ptr_nxt];
    end
  end

  // Write port
  always_ff @(posedge clk) begin
    if (!rst && push_c) begin
      mem[wr_ptr] <= in_data;
    end
  end

  // Pointers, level, flags and the registered head of the queue
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      rd_ptr    <= rd_ptr_nxt;
      wr_ptr    <= wr_ptr_nxt;
      level     <= level_nxt;
      full      <= (level_nxt == LW'(DEPTH));
      empty     <= (level_nxt == '0);
      out_valid <= (level_nxt != '0);
      out_data  <= head_nxt;
    end
  end

  // Sticky overflow flag; a drop in the clearing cycle keeps it set
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (drop_c) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end

`ifdef ACCU_FIFO_DROP_CNT_EN
  // Saturating drop counter; a drop in the clearing cycle restarts at 1
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= 8'd0;
    end else if (ovf_clr) begin
      drop_cnt <= drop_c ? 8'd1 : 8'd0;
    end else if (drop_c && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'd1;
    end
  end
`else
  // Drop counter not built; drops are reported through ovf only
`endif

endmodule

// File: tb/tb_accu_result_fifo.sv
// Bench for accu_result_fifo: directed scenarios followed by random traffic,
// checked every cycle against a queue-based reference model.
module tb_accu_result_fifo;

  localparam int unsigned DW    = 10;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready = 1'b0;
  logic [LW-1:0] level;
  logic          full;
  logic          empty;
  logic          ovf;
  logic          ovf_clr = 1'b0;
`ifdef ACCU_FIFO_DROP_CNT_EN
  logic [7:0]    drop_cnt;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            ovf_m;
  int            drop_m;

  accu_result_fifo #(.DW(DW), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .level     (level),
    .full      (full),
    .empty     (empty),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
`ifdef ACCU_FIFO_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    check_eq("out_valid", 32'(out_valid), 32'(q.size() > 0));
    check_eq("level", 32'(level), 32'(q.size()));
    check_eq("full", 32'(full), 32'(q.size() == DEPTH));
    check_eq("empty", 32'(empty), 32'(q.size() == 0));
    check_eq("ovf", 32'(ovf), 32'(ovf_m));
    if (q.size() > 0) begin
      check_eq("out_data", 32'(out_data), 32'(q[0]));
    end
`ifdef ACCU_FIFO_DROP_CNT_EN
    check_eq("drop_cnt", 32'(drop_cnt), 32'(drop_m));
`endif
  endtask

  // One clock: drive inputs, predict from the model, compare after the edge
  task automatic cycle(input bit r, input bit iv, input logic [DW-1:0] d,
                       input bit rdy, input bit clr);
    bit m_full;
    bit m_pop;
    bit m_push;
    bit m_drop;
    rst       = r;
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    ovf_clr   = clr;
    m_full = (q.size() == DEPTH);
    m_pop  = (q.size() > 0) && rdy;
    m_push = iv && (!m_full || m_pop);
    m_drop = iv && m_full && !m_pop;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      ovf_m  = 1'b0;
      drop_m = 0;
    end else begin
      if (m_pop) void'(q.pop_front());
      if (m_push) q.push_back(d);
      if (m_drop) ovf_m = 1'b1;
      else if (clr) ovf_m = 1'b0;
      if (clr) drop_m = m_drop ? 1 : 0;
      else if (m_drop && drop_m < 255) drop_m++;
    end
    check_state();
  endtask

  initial begin
    logic [DW-1:0] vals [4];
    int rdy_pct;
    vals[0] = 10'd20; vals[1] = 10'd114; vals[2] = 10'd68; vals[3] = 10'd7;

    // 1: reset held with in_valid asserted
    cycle(1, 1, 10'd321, 1, 0);
    cycle(1, 1, 10'd322, 1, 0);
    check_eq("rst_out_data", 32'(out_data), 32'd0);

    // 2: passthrough, strobes spaced 4 cycles apart
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, vals[i], 1, 0);
      check_eq("pt_head", 32'(out_data), 32'(vals[i]));
      check_eq("pt_level_le1", 32'(level <= 1), 32'd1);
      for (int k = 0; k < 3; k++) begin
        cycle(0, 0, '0, 1, 0);
        check_eq("pt_level_le1", 32'(level <= 1), 32'd1);
      end
    end

    // 3: fill while stalled, then drain back to back
    for (int i = 0; i < 4; i++) cycle(0, 1, vals[i], 0, 0);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_level", 32'(level), 32'd4);
    for (int i = 0; i < 4; i++) begin
      check_eq("drain_order", 32'(out_data), 32'(vals[i]));
      cycle(0, 0, '0, 1, 0);
    end
    check_eq("drain_empty", 32'(empty), 32'd1);

    // 4: overflow while full and stalled, then clear
    for (int i = 0; i < 4; i++) cycle(0, 1, vals[i], 0, 0);
    cycle(0, 1, 10'd999, 0, 0);
    check_eq("ovf_set", 32'(ovf), 32'd1);
    check_eq("ovf_head_kept", 32'(out_data), 32'd20);
    check_eq("ovf_level_kept", 32'(level), 32'd4);
    cycle(0, 0, '0, 0, 1);
    check_eq("ovf_cleared", 32'(ovf), 32'd0);

    // 5: full with simultaneous push and pop
    cycle(0, 1, 10'd55, 1, 0);
    check_eq("pp_level", 32'(level), 32'd4);
    check_eq("pp_ovf", 32'(ovf), 32'd0);
    check_eq("pp_head", 32'(out_data), 32'd114);
    for (int i = 0; i < 4; i++) cycle(0, 0, '0, 1, 0);
    check_eq("pp_empty", 32'(empty), 32'd1);

    // 6: reset with three entries stored
    for (int i = 0; i < 3; i++) cycle(0, 1, vals[i], 0, 0);
    check_eq("mid_level3", 32'(level), 32'd3);
    cycle(1, 0, '0, 0, 0);
    check_eq("mid_rst_level", 32'(level), 32'd0);
    cycle(0, 1, 10'd5, 0, 0);
    check_eq("mid_new_head", 32'(out_data), 32'd5);
    cycle(0, 0, '0, 1, 0);

    // Random traffic with varying consumer stall rates
    for (int ph = 0; ph < 4; ph++) begin
      rdy_pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 60;
      for (int n = 0; n < 1500; n++) begin
        cycle(($urandom_range(0, 299) == 0),
              ($urandom_range(0, 99) < 60),
              DW'($urandom),
              ($urandom_range(0, 99) < rdy_pct),
              ($urandom_range(0, 39) == 0));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
